// File: rtl/aq_ejpeg_rgb2ycbcr.sv
// RGB -> YCbCr front end of the JPEG encoder.
// Takes one MCU of RGB pixels in block order. Each pixel goes through a
// 3-stage pipeline that produces level-shifted signed 9-bit Y/Cb/Cr values
// and the Y and CbCr buffer addresses. Cb/Cr are decimated top-left to match
// the layout that the decoder's colour converter reads.
module aq_ejpeg_rgb2ycbcr #(
    parameter int COEF_FRAC = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              InStart,
    input  logic [2:0]        InComp,
    input  logic [1:0]        SubSamplingW,
    input  logic [1:0]        SubSamplingH,
    input  logic              InValid,
    output logic              InReady,
    input  logic [7:0]        InR,
    input  logic [7:0]        InG,
    input  logic [7:0]        InB,
    input  logic              OutReady,
    output logic              OutEnable,
    output logic              OutWriteCbCr,
    output logic [7:0]        OutAddressY,
    output logic [7:0]        OutAddressCbCr,
    output logic signed [8:0] OutY,
    output logic signed [8:0] OutCb,
    output logic signed [8:0] OutCr,
    output logic              Busy,
    output logic              BlockDone
);

    localparam int DATA_W = 8;
    localparam int COEF_W = 15;
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = 26;

    // Coefficient magnitudes scaled by 2^COEF_FRAC; the signs are applied in the sums.
    localparam logic [COEF_W-1:0] C_YR  = 15'h1323;
    localparam logic [COEF_W-1:0] C_YG  = 15'h2591;
    localparam logic [COEF_W-1:0] C_YB  = 15'h074C;
    localparam logic [COEF_W-1:0] C_CBR = 15'h0ACC;
    localparam logic [COEF_W-1:0] C_CBG = 15'h1534;
    localparam logic [COEF_W-1:0] C_CBB = 15'h2000;
    localparam logic [COEF_W-1:0] C_CRR = 15'h2000;
    localparam logic [COEF_W-1:0] C_CRG = 15'h1ACC;
    localparam logic [COEF_W-1:0] C_CRB = 15'h0534;

    localparam logic signed [ACC_W-1:0] RND      = ACC_W'(1) << (COEF_FRAC - 1);
    localparam logic signed [ACC_W-1:0] LUMA_OFS = 26'sd128;
    localparam logic signed [ACC_W-1:0] SAT_HI   = 26'sd127;
    localparam logic signed [ACC_W-1:0] SAT_LO   = -26'sd128;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    function automatic logic [PROD_W-1:0] umul(input logic [DATA_W-1:0] a,
                                               input logic [COEF_W-1:0] c);
        return {{COEF_W{1'b0}}, a} * {{DATA_W{1'b0}}, c};
    endfunction

    function automatic logic signed [ACC_W-1:0] ext(input logic [PROD_W-1:0] p);
        return $signed({{(ACC_W-PROD_W){1'b0}}, p});
    endfunction

    // Round half up, drop the fractional bits, optional luma level shift, clamp to 8-bit signed.
    function automatic logic signed [8:0] round_sat(input logic signed [ACC_W-1:0] sum,
                                                    input logic luma);
        logic signed [ACC_W-1:0] t;
        t = (sum + RND) >>> COEF_FRAC;
        if (luma)
            t = t - LUMA_OFS;
        if (t > SAT_HI)
            return 9'sd127;
        else if (t < SAT_LO)
            return -9'sd128;
        else
            return t[8:0];
    endfunction

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_comp3;
    logic              r_w2;
    logic              r_h2;
    logic [7:0]        r_count;

    logic              w_accept;
    logic [3:0]        w_x;
    logic [3:0]        w_y;
    logic [7:0]        w_addry;
    logic [7:0]        w_addrc;
    logic              w_wcbcr;
    logic [7:0]        w_nlast;
    logic              w_last;

    logic              r_vld_p0;
    logic              r_last_p0;
    logic              r_wc_p0;
    logic [7:0]        r_addry_p0;
    logic [7:0]        r_addrc_p0;
    logic [DATA_W-1:0] r_red_p0;
    logic [DATA_W-1:0] r_grn_p0;
    logic [DATA_W-1:0] r_blu_p0;

    logic              r_vld_p1;
    logic              r_last_p1;
    logic              r_wc_p1;
    logic [7:0]        r_addry_p1;
    logic [7:0]        r_addrc_p1;
    logic [PROD_W-1:0] r_yr_p1;
    logic [PROD_W-1:0] r_yg_p1;
    logic [PROD_W-1:0] r_yb_p1;
    logic [PROD_W-1:0] r_cbr_p1;
    logic [PROD_W-1:0] r_cbg_p1;
    logic [PROD_W-1:0] r_cbb_p1;
    logic [PROD_W-1:0] r_crr_p1;
    logic [PROD_W-1:0] r_crg_p1;
    logic [PROD_W-1:0] r_crb_p1;

    logic signed [ACC_W-1:0] w_sum_y;
    logic signed [ACC_W-1:0] w_sum_cb;
    logic signed [ACC_W-1:0] w_sum_cr;

    logic              r_vld_p2;
    logic              r_last_p2;
    logic              r_wc_p2;
    logic [7:0]        r_addry_p2;
    logic [7:0]        r_addrc_p2;
    logic signed [8:0] r_y_p2;
    logic signed [8:0] r_cb_p2;
    logic signed [8:0] r_cr_p2;

    // Pixel coordinates and buffer addresses derived from the in-MCU count.
    assign w_accept = InValid && InReady;
    assign w_x      = r_w2 ? r_count[3:0] : {1'b0, r_count[2:0]};
    assign w_y      = r_w2 ? r_count[7:4] : r_count[6:3];
    assign w_addry  = {w_y, w_x};
    assign w_addrc  = {(r_h2 ? w_y[3:1] : w_y[2:0]), 1'b0,
                       (r_w2 ? w_x[3:1] : w_x[2:0]), 1'b0};
    assign w_wcbcr  = r_comp3 && (!r_w2 || !w_x[0]) && (!r_h2 || !w_y[0]);
    assign w_nlast  = {r_w2 & r_h2, r_w2 | r_h2, 6'h3F};
    assign w_last   = (r_count == w_nlast);

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // FSM next state and input handshake.
    always_comb begin
        w_state_nxt = r_state;
        InReady     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (InStart)
                    w_state_nxt = S_RUN;
            end
            S_RUN: begin
                InReady = OutReady;
                if (InValid && OutReady && w_last)
                    w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (OutReady && r_vld_p2 && r_last_p2)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Block configuration, latched once per MCU; grey forces 1x1 sampling.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_comp3 <= 1'b0;
            r_w2    <= 1'b0;
            r_h2    <= 1'b0;
        end else if (r_state == S_IDLE && InStart) begin
            r_comp3 <= (InComp == 3'd3);
            r_w2    <= (InComp == 3'd3) && (SubSamplingW == 2'd2);
            r_h2    <= (InComp == 3'd3) && (SubSamplingH == 2'd2);
        end
    end

    // Pixel count within the MCU, advancing only on accepted pixels.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_count <= 8'd0;
        else if (r_state == S_IDLE && InStart)
            r_count <= 8'd0;
        else if (w_accept)
            r_count <= r_count + 8'd1;
    end

    // ---- stage 1: capture pixel, addresses and write flags ----
    // Stage 1 valid and flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_p0  <= 1'b0;
            r_last_p0 <= 1'b0;
            r_wc_p0   <= 1'b0;
        end else if (OutReady) begin
            r_vld_p0  <= w_accept;
            r_last_p0 <= w_accept && w_last;
            r_wc_p0   <= w_accept && w_wcbcr;
        end
    end

    // Stage 1 pixel and address data.
    always_ff @(posedge clk) begin
        if (OutReady) begin
            r_red_p0   <= InR;
            r_grn_p0   <= InG;
            r_blu_p0   <= InB;
            r_addry_p0 <= w_addry;
            r_addrc_p0 <= w_addrc;
        end
    end

    // ---- stage 2: nine unsigned products ----
    // Stage 2 valid and flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_p1  <= 1'b0;
            r_last_p1 <= 1'b0;
            r_wc_p1   <= 1'b0;
        end else if (OutReady) begin
            r_vld_p1  <= r_vld_p0;
            r_last_p1 <= r_last_p0;
            r_wc_p1   <= r_wc_p0;
        end
    end

    // Stage 2 products and forwarded addresses.
    always_ff @(posedge clk) begin
        if (OutReady) begin
            r_yr_p1    <= umul(r_red_p0, C_YR);
            r_yg_p1    <= umul(r_grn_p0, C_YG);
            r_yb_p1    <= umul(r_blu_p0, C_YB);
            r_cbr_p1   <= umul(r_red_p0, C_CBR);
            r_cbg_p1   <= umul(r_grn_p0, C_CBG);
            r_cbb_p1   <= umul(r_blu_p0, C_CBB);
            r_crr_p1   <= umul(r_red_p0, C_CRR);
            r_crg_p1   <= umul(r_grn_p0, C_CRG);
            r_crb_p1   <= umul(r_blu_p0, C_CRB);
            r_addry_p1 <= r_addry_p0;
            r_addrc_p1 <= r_addrc_p0;
        end
    end

    // ---- stage 3: signed sums, rounding, saturation, output registers ----
    assign w_sum_y  = ext(r_yr_p1) + ext(r_yg_p1) + ext(r_yb_p1);
    assign w_sum_cb = ext(r_cbb_p1) - ext(r_cbr_p1) - ext(r_cbg_p1);
    assign w_sum_cr = ext(r_crr_p1) - ext(r_crg_p1) - ext(r_crb_p1);

    // Output registers; cleared by reset so nothing is written after an abort.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_p2   <= 1'b0;
            r_last_p2  <= 1'b0;
            r_wc_p2    <= 1'b0;
            r_addry_p2 <= 8'd0;
            r_addrc_p2 <= 8'd0;
            r_y_p2     <= 9'sd0;
            r_cb_p2    <= 9'sd0;
            r_cr_p2    <= 9'sd0;
        end else if (OutReady) begin
            r_vld_p2   <= r_vld_p1;
            r_last_p2  <= r_vld_p1 && r_last_p1;
            r_wc_p2    <= r_vld_p1 && r_wc_p1;
            r_addry_p2 <= r_addry_p1;
            r_addrc_p2 <= r_addrc_p1;
            r_y_p2     <= round_sat(w_sum_y, 1'b1);
            r_cb_p2    <= r_comp3 ? round_sat(w_sum_cb, 1'b0) : 9'sd0;
            r_cr_p2    <= r_comp3 ? round_sat(w_sum_cr, 1'b0) : 9'sd0;
        end
    end

    assign OutEnable      = r_vld_p2;
    assign OutWriteCbCr   = r_wc_p2;
    assign OutAddressY    = r_addry_p2;
    assign OutAddressCbCr = r_addrc_p2;
    assign OutY           = r_y_p2;
    assign OutCb          = r_cb_p2;
    assign OutCr          = r_cr_p2;
    assign BlockDone      = r_last_p2;
    assign Busy           = (r_state != S_IDLE);

endmodule
